// File: rtl/bp_table.sv
// bp_table: compacted breakpoint table for the PDU debug path.
// Holds up to DEPTH addresses in insertion order (valid = index < bp_count).
// It compares every entry against the committed PC each cycle and raises a
// registered hit pulse. Supports add, delete-by-address and clear commands,
// with optional one-shot removal of an entry when it hits.
module bp_table #(
  parameter int DEPTH   = 8,
  parameter int AW      = 32,
  parameter int ONESHOT = 1,
  localparam int CW     = $clog2(DEPTH + 1),
  localparam int IW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] bp_addr,
  input  logic          bp_we,
  input  logic          bp_del,
  input  logic          bp_clear,
  input  logic [AW-1:0] pc,
  input  logic          pc_valid,
  output logic          hit,
  output logic [IW-1:0] hit_idx,
  output logic [AW-1:0] hit_addr,
  output logic [CW-1:0] bp_count,
  output logic          full,
  output logic          empty,
  output logic          op_done,
  output logic          op_err
);

  logic [AW-1:0] entry_q [DEPTH];
  logic [AW-1:0] entry_d [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic          hit_q, hit_d;
  logic [IW-1:0] hit_idx_q, hit_idx_d;
  logic [AW-1:0] hit_addr_q, hit_addr_d;
  logic          op_done_q, op_done_d;
  logic          op_err_q, op_err_d;

  logic [DEPTH-1:0] match;
  logic             any_match;
  logic [IW-1:0]    match_idx;
  logic [AW-1:0]    match_addr;
  logic [DEPTH-1:0] addr_eq;
  logic             addr_found;
  logic [IW-1:0]    addr_idx;
  logic             full_w;
  logic             rm_en;
  logic [IW-1:0]    rm_idx;

  assign full_w = (count_q == CW'(DEPTH));

  // PC compare and bp_addr lookup against the valid entries, lowest index wins
  always_comb begin
    match      = '0;
    addr_eq    = '0;
    match_idx  = '0;
    match_addr = '0;
    addr_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      match[k]   = pc_valid && (CW'(k) < count_q) && (entry_q[k] == pc);
      addr_eq[k] = (CW'(k) < count_q) && (entry_q[k] == bp_addr);
    end
    // Scan downwards so the last assignment is the lowest set index.
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match[k]) begin
        match_idx  = IW'(k);
        match_addr = entry_q[k];
      end
      if (addr_eq[k]) begin
        addr_idx = IW'(k);
      end
    end
    any_match  = |match;
    addr_found = |addr_eq;
  end

  // Next table state: clear > one-shot removal > delete > add, one update per edge
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      entry_d[k] = entry_q[k];
    end
    count_d    = count_q;
    hit_d      = any_match;
    hit_idx_d  = any_match ? match_idx : hit_idx_q;
    hit_addr_d = any_match ? match_addr : hit_addr_q;
    op_done_d  = bp_we | bp_del | bp_clear;
    op_err_d   = 1'b0;
    rm_en      = 1'b0;
    rm_idx     = '0;

    if (bp_clear) begin
      for (int k = 0; k < DEPTH; k++) begin
        entry_d[k] = '0;
      end
      count_d = '0;
    end else if ((ONESHOT != 0) && any_match) begin
      // The hit consumes this edge's update slot; any command is dropped.
      rm_en    = 1'b1;
      rm_idx   = match_idx;
      count_d  = count_q - CW'(1);
      op_err_d = op_done_d;
    end else if (bp_del) begin
      if (addr_found) begin
        rm_en   = 1'b1;
        rm_idx  = addr_idx;
        count_d = count_q - CW'(1);
      end else begin
        op_err_d = 1'b1;
      end
    end else if (bp_we) begin
      if (addr_found || full_w) begin
        op_err_d = 1'b1;
      end else begin
        for (int k = 0; k < DEPTH; k++) begin
          if (CW'(k) == count_q) begin
            entry_d[k] = bp_addr;
          end
        end
        count_d = count_q + CW'(1);
      end
    end

    // Compaction: everything above the removed slot moves down one place,
    // and the slot vacated at the top is zeroed.
    if (rm_en) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (IW'(k) >= rm_idx) begin
          if ((k < DEPTH - 1) && (CW'(k + 1) < count_q)) begin
            entry_d[k] = entry_q[(k < DEPTH - 1) ? k + 1 : k];
          end else begin
            entry_d[k] = '0;
          end
        end
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        entry_q[k] <= '0;
      end
      count_q    <= '0;
      hit_q      <= 1'b0;
      hit_idx_q  <= '0;
      hit_addr_q <= '0;
      op_done_q  <= 1'b0;
      op_err_q   <= 1'b0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        entry_q[k] <= entry_d[k];
      end
      count_q    <= count_d;
      hit_q      <= hit_d;
      hit_idx_q  <= hit_idx_d;
      hit_addr_q <= hit_addr_d;
      op_done_q  <= op_done_d;
      op_err_q   <= op_err_d;
    end
  end

  assign hit      = hit_q;
  assign hit_idx  = hit_idx_q;
  assign hit_addr = hit_addr_q;
  assign bp_count = count_q;
  assign full     = full_w;
  assign empty    = (count_q == '0);
  assign op_done  = op_done_q;
  assign op_err   = op_err_q;

endmodule

// File: tb/tb_bp_table.sv
// Testbench for bp_table: one one-shot and one persistent instance share the
// same stimulus; a queue-based reference model predicts both every cycle.
module tb_bp_table;

  localparam int DEPTH = 8;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] bp_addr = '0;
  logic          bp_we = 1'b0, bp_del = 1'b0, bp_clear = 1'b0;
  logic [AW-1:0] pc = '0;
  logic          pc_valid = 1'b0;

  logic          o_hit   [2];
  logic [2:0]    o_idx   [2];
  logic [AW-1:0] o_haddr [2];
  logic [3:0]    o_cnt   [2];
  logic          o_full  [2];
  logic          o_empty [2];
  logic          o_done  [2];
  logic          o_err   [2];

  bp_table #(.DEPTH(DEPTH), .AW(AW), .ONESHOT(1)) u_os (
    .clk(clk), .rst(rst), .bp_addr(bp_addr), .bp_we(bp_we), .bp_del(bp_del),
    .bp_clear(bp_clear), .pc(pc), .pc_valid(pc_valid),
    .hit(o_hit[0]), .hit_idx(o_idx[0]), .hit_addr(o_haddr[0]), .bp_count(o_cnt[0]),
    .full(o_full[0]), .empty(o_empty[0]), .op_done(o_done[0]), .op_err(o_err[0]));

  bp_table #(.DEPTH(DEPTH), .AW(AW), .ONESHOT(0)) u_ps (
    .clk(clk), .rst(rst), .bp_addr(bp_addr), .bp_we(bp_we), .bp_del(bp_del),
    .bp_clear(bp_clear), .pc(pc), .pc_valid(pc_valid),
    .hit(o_hit[1]), .hit_idx(o_idx[1]), .hit_addr(o_haddr[1]), .bp_count(o_cnt[1]),
    .full(o_full[1]), .empty(o_empty[1]), .op_done(o_done[1]), .op_err(o_err[1]));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: index 0 one-shot, index 1 persistent.
  logic [AW-1:0] tbl [2][$];
  bit            e_hit  [2];
  int            e_idx  [2];
  logic [AW-1:0] e_addr [2];
  bit            e_done [2];
  bit            e_err  [2];

  typedef struct {
    bit            we, del, clr, pcv;
    logic [AW-1:0] addr, pc;
    int            cnt;
    bit            hit;
    int            idx;
    logic [AW-1:0] haddr;
    bit            done, err;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit we, bit del, bit clr, logic [AW-1:0] addr, bit pcv,
                              logic [AW-1:0] pcx, int cnt, bit h, int idx,
                              logic [AW-1:0] haddr, bit done, bit err);
    vec_t v;
    v.we = we; v.del = del; v.clr = clr; v.addr = addr; v.pcv = pcv; v.pc = pcx;
    v.cnt = cnt; v.hit = h; v.idx = idx; v.haddr = haddr; v.done = done; v.err = err;
    return v;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      tbl[m].delete();
      e_hit[m] = 0; e_idx[m] = 0; e_addr[m] = '0; e_done[m] = 0; e_err[m] = 0;
    end
  endtask

  // Apply the rules to the table as it stands before the edge.
  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      int  mi, di;
      bit  dup, done, err;
      mi = -1;
      if (pc_valid) begin
        for (int k = 0; k < tbl[m].size(); k++)
          if (mi < 0 && tbl[m][k] == pc) mi = k;
      end
      e_hit[m] = (mi >= 0);
      if (mi >= 0) begin
        e_idx[m]  = mi;
        e_addr[m] = tbl[m][mi];
      end
      done = bp_we | bp_del | bp_clear;
      err  = 0;
      if (bp_clear) begin
        tbl[m].delete();
      end else if (m == 0 && mi >= 0) begin
        tbl[m].delete(mi);
        err = done;
      end else if (bp_del) begin
        di = -1;
        for (int k = 0; k < tbl[m].size(); k++)
          if (di < 0 && tbl[m][k] == bp_addr) di = k;
        if (di < 0) err = 1;
        else tbl[m].delete(di);
      end else if (bp_we) begin
        dup = 0;
        for (int k = 0; k < tbl[m].size(); k++)
          if (tbl[m][k] == bp_addr) dup = 1;
        if (dup || tbl[m].size() >= DEPTH) err = 1;
        else tbl[m].push_back(bp_addr);
      end
      e_done[m] = done;
      e_err[m]  = err;
    end
  endtask

  task automatic model_check();
    for (int m = 0; m < 2; m++) begin
      string s;
      s = (m == 0) ? "os" : "ps";
      chk({s, ".hit"},      AW'(o_hit[m]),   AW'(e_hit[m]));
      chk({s, ".hit_idx"},  AW'(o_idx[m]),   AW'(e_idx[m]));
      chk({s, ".hit_addr"}, o_haddr[m],      e_addr[m]);
      chk({s, ".bp_count"}, AW'(o_cnt[m]),   AW'(tbl[m].size()));
      chk({s, ".full"},     AW'(o_full[m]),  AW'(tbl[m].size() == DEPTH));
      chk({s, ".empty"},    AW'(o_empty[m]), AW'(tbl[m].size() == 0));
      chk({s, ".op_done"},  AW'(o_done[m]),  AW'(e_done[m]));
      chk({s, ".op_err"},   AW'(o_err[m]),   AW'(e_err[m]));
    end
  endtask

  // One clock: predict from the current inputs, take the edge, compare 1ns later.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic set_in(bit we, bit del, bit clr, logic [AW-1:0] addr, bit pcv, logic [AW-1:0] pcx);
    bp_we = we; bp_del = del; bp_clear = clr; bp_addr = addr; pc_valid = pcv; pc = pcx;
  endtask

  task automatic chk_reset_state(input string tag);
    for (int m = 0; m < 2; m++) begin
      chk({tag, ".hit"},      AW'(o_hit[m]),   '0);
      chk({tag, ".hit_idx"},  AW'(o_idx[m]),   '0);
      chk({tag, ".hit_addr"}, o_haddr[m],      '0);
      chk({tag, ".bp_count"}, AW'(o_cnt[m]),   '0);
      chk({tag, ".full"},     AW'(o_full[m]),  '0);
      chk({tag, ".empty"},    AW'(o_empty[m]), AW'(1));
      chk({tag, ".op_done"},  AW'(o_done[m]),  '0);
      chk({tag, ".op_err"},   AW'(o_err[m]),   '0);
    end
  endtask

  initial begin
    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("rst");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors on the one-shot instance (the model checks both).
    //             we del clr addr     pcv pc      cnt hit idx haddr  done err
    vecs.push_back(mk(1, 0, 0, 'h100, 0, 'h0,   1, 0, 0, 'h0,   1, 0));
    vecs.push_back(mk(1, 0, 0, 'h200, 0, 'h0,   2, 0, 0, 'h0,   1, 0));
    vecs.push_back(mk(1, 0, 0, 'h300, 0, 'h0,   3, 0, 0, 'h0,   1, 0));
    vecs.push_back(mk(1, 0, 0, 'h400, 0, 'h0,   4, 0, 0, 'h0,   1, 0));
    vecs.push_back(mk(1, 0, 0, 'h500, 0, 'h0,   5, 0, 0, 'h0,   1, 0));
    vecs.push_back(mk(1, 0, 0, 'h600, 0, 'h0,   6, 0, 0, 'h0,   1, 0));
    vecs.push_back(mk(1, 0, 0, 'h700, 0, 'h0,   7, 0, 0, 'h0,   1, 0));
    vecs.push_back(mk(1, 0, 0, 'h800, 0, 'h0,   8, 0, 0, 'h0,   1, 0));
    vecs.push_back(mk(1, 0, 0, 'h900, 0, 'h0,   8, 0, 0, 'h0,   1, 1));
    vecs.push_back(mk(1, 0, 0, 'h100, 0, 'h0,   8, 0, 0, 'h0,   1, 1));
    vecs.push_back(mk(0, 1, 0, 'h200, 0, 'h0,   7, 0, 0, 'h0,   1, 0));
    vecs.push_back(mk(0, 1, 0, 'h200, 0, 'h0,   7, 0, 0, 'h0,   1, 1));
    vecs.push_back(mk(0, 0, 0, 'h0,   1, 'h300, 6, 1, 1, 'h300, 0, 0));
    vecs.push_back(mk(0, 0, 0, 'h0,   1, 'h300, 6, 0, 1, 'h300, 0, 0));
    vecs.push_back(mk(1, 0, 0, 'h900, 1, 'h100, 5, 1, 0, 'h100, 1, 1));
    vecs.push_back(mk(0, 0, 1, 'h0,   1, 'h400, 0, 1, 0, 'h400, 1, 0));
    vecs.push_back(mk(0, 0, 0, 'h0,   0, 'h0,   0, 0, 0, 'h400, 0, 0));
    vecs.push_back(mk(1, 1, 0, 'h500, 0, 'h0,   0, 0, 0, 'h400, 1, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      set_in(vecs[i].we, vecs[i].del, vecs[i].clr, vecs[i].addr, vecs[i].pcv, vecs[i].pc);
      cyc();
      chk($sformatf("vec%0d.bp_count", i), AW'(o_cnt[0]), AW'(vecs[i].cnt));
      chk($sformatf("vec%0d.hit", i),      AW'(o_hit[0]), AW'(vecs[i].hit));
      chk($sformatf("vec%0d.hit_idx", i),  AW'(o_idx[0]), AW'(vecs[i].idx));
      chk($sformatf("vec%0d.hit_addr", i), o_haddr[0],    vecs[i].haddr);
      chk($sformatf("vec%0d.op_done", i),  AW'(o_done[0]), AW'(vecs[i].done));
      chk($sformatf("vec%0d.op_err", i),   AW'(o_err[0]),  AW'(vecs[i].err));
    end

    // One-shot: table {0x100,0x200}, pc=0x200 held for two cycles
    set_in(0, 0, 1, 'h0, 0, 'h0);   cyc();
    set_in(1, 0, 0, 'h100, 0, 'h0); cyc();
    set_in(1, 0, 0, 'h200, 0, 'h0); cyc();
    set_in(0, 0, 0, 'h0, 1, 'h200); cyc();
    chk("os2.hit1",      AW'(o_hit[0]), AW'(1));
    chk("os2.idx1",      AW'(o_idx[0]), AW'(1));
    chk("os2.addr1",     o_haddr[0],    'h200);
    cyc();
    chk("os2.hit2",      AW'(o_hit[0]), AW'(0));
    chk("os2.count",     AW'(o_cnt[0]), AW'(1));
    chk("ps2.hit2",      AW'(o_hit[1]), AW'(1));
    chk("ps2.count",     AW'(o_cnt[1]), AW'(2));

    // Reset mid-sequence with 3 entries and a pending match
    set_in(0, 0, 1, 'h0, 0, 'h0);   cyc();
    set_in(1, 0, 0, 'h100, 0, 'h0); cyc();
    set_in(1, 0, 0, 'h200, 0, 'h0); cyc();
    set_in(1, 0, 0, 'h300, 0, 'h0); cyc();
    set_in(0, 0, 0, 'h0, 1, 'h200);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk_reset_state("midrst");
    @(negedge clk);
    rst = 1'b1;
    cyc();
    chk("midrst.nohit", AW'(o_hit[0]), AW'(0));
    cyc();

    // Randomised traffic over a small address pool
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      set_in(r < 45, (r >= 45 && r < 70), (r >= 97),
             AW'('h40 + 4 * $urandom_range(0, 11)),
             $urandom_range(0, 2) != 0,
             AW'('h40 + 4 * $urandom_range(0, 11)));
      if ($urandom_range(0, 9) == 0) begin
        bp_we = 1'b1; bp_del = 1'b1;
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
